// File: rtl/sme_feeder_pkg.sv
// Shared constants, state encoding and bus payload type for the string-matching engine feeder.
package sme_pkg;

  localparam int unsigned STR_DEPTH = 32;
  localparam int unsigned PAT_DEPTH = 10;
  localparam int unsigned STR_IW    = $clog2(STR_DEPTH);
  localparam int unsigned PAT_IW    = $clog2(PAT_DEPTH);

  localparam logic [7:0] HAT    = 8'h5E;
  localparam logic [7:0] DOLLAR = 8'h24;
  localparam logic [7:0] DOT    = 8'h2E;
  localparam logic [7:0] SPACE  = 8'h20;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_STR = 3'd1,
    SEND_PAT = 3'd2,
    GAP      = 3'd3,
    WAIT     = 3'd4,
    REPORT   = 3'd5
  } state_t;

  // One character beat toward the engine.
  typedef struct packed {
    logic       isstring;
    logic       ispattern;
    logic [7:0] chardata;
  } sme_char_t;

endpackage

// File: rtl/sme_feeder_if.sv
// Host and engine signals of the feeder; master is the feeder, slave is the host/engine side.
interface sme_feeder_if;
  import sme_pkg::*;

  logic              wr_en;
  logic              wr_sel;
  logic [7:0]        wr_data;
  logic              clear;
  logic              start;
  logic              keep_string;
  logic              busy;
  logic              done;
  logic              res_match;
  logic [STR_IW-1:0] res_index;
  logic              timeout_err;
  logic              ovf;
  logic [7:0]        chardata;
  logic              isstring;
  logic              ispattern;
  logic              sme_valid;
  logic              sme_match;
  logic [STR_IW-1:0] sme_match_index;

  modport master (
    input  wr_en, wr_sel, wr_data, clear, start, keep_string,
    input  sme_valid, sme_match, sme_match_index,
    output busy, done, res_match, res_index, timeout_err, ovf,
    output chardata, isstring, ispattern
  );

  modport slave (
    output wr_en, wr_sel, wr_data, clear, start, keep_string,
    output sme_valid, sme_match, sme_match_index,
    input  busy, done, res_match, res_index, timeout_err, ovf,
    input  chardata, isstring, ispattern
  );

endinterface

// File: rtl/sme_feeder_char_buf.sv
// Append-only character buffer with length counter, sticky overflow flag and indexed read.
module sme_char_buf #(
  parameter int unsigned DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic [7:0]                   wr_data,
  input  logic [$clog2(DEPTH)-1:0]     rd_idx,
  output logic [7:0]                   rd_data_c,
  output logic [$clog2(DEPTH+1)-1:0]   len,
  output logic                         ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [7:0] mem [DEPTH];
  logic       full_c;

  assign full_c    = (len == LW'(DEPTH));
  assign rd_data_c = mem[rd_idx];

  // Length and overflow; clear wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      len <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      len <= '0;
      ovf <= 1'b0;
    end else if (wr_en) begin
      if (full_c) ovf <= 1'b1;
      else        len <= len + LW'(1);
    end
  end

  // Storage is not reset; only the length defines valid contents.
  always_ff @(posedge clk) begin
    if (reset && !clear && wr_en && !full_c) mem[len[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sme_feeder.sv
// Serialises host-loaded string and pattern buffers to the matching engine and returns its result.
module sme_feeder
  import sme_pkg::*;
#(
  parameter int unsigned STR_DEPTH = sme_pkg::STR_DEPTH,
  parameter int unsigned PAT_DEPTH = sme_pkg::PAT_DEPTH,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic         clk,
  input  logic         reset,
  sme_feeder_if.master bus
);

  localparam int unsigned SLW = $clog2(STR_DEPTH + 1);
  localparam int unsigned PLW = $clog2(PAT_DEPTH + 1);
  localparam int unsigned SAW = $clog2(STR_DEPTH);
  localparam int unsigned PAW = $clog2(PAT_DEPTH);
  localparam int unsigned CW  = $clog2(TIMEOUT);

  state_t            state, state_n;
  logic [SLW-1:0]    idx, idx_n;
  logic [CW-1:0]     wcnt, wcnt_n;
  logic              str_sent, str_sent_n;
  logic              cap_match, cap_match_n;
  logic              cap_tmo, cap_tmo_n;
  logic [STR_IW-1:0] cap_index, cap_index_n;

  logic [SLW-1:0]    str_len;
  logic [PLW-1:0]    pat_len;
  logic [7:0]        str_rd_c, pat_rd_c;
  logic              str_ovf, pat_ovf;
  logic              in_idle_c, start_ok_c;

  sme_char_t         tx_d, tx_q;
  logic              busy_d, done_d, tmo_d, match_d, ovf_d;
  logic [STR_IW-1:0] index_d;

  assign in_idle_c  = (state == IDLE);
  assign start_ok_c = bus.start && (pat_len != '0) &&
                      ((str_len != '0) || (bus.keep_string && str_sent));

  sme_char_buf #(.DEPTH(STR_DEPTH)) u_str_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.clear && in_idle_c),
    .wr_en     (bus.wr_en && !bus.wr_sel && in_idle_c),
    .wr_data   (bus.wr_data),
    .rd_idx    (idx[SAW-1:0]),
    .rd_data_c (str_rd_c),
    .len       (str_len),
    .ovf       (str_ovf)
  );

  sme_char_buf #(.DEPTH(PAT_DEPTH)) u_pat_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.clear && in_idle_c),
    .wr_en     (bus.wr_en && bus.wr_sel && in_idle_c),
    .wr_data   (bus.wr_data),
    .rd_idx    (idx[PAW-1:0]),
    .rd_data_c (pat_rd_c),
    .len       (pat_len),
    .ovf       (pat_ovf)
  );

  assign bus.isstring  = tx_q.isstring;
  assign bus.ispattern = tx_q.ispattern;
  assign bus.chardata  = tx_q.chardata;

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      idx             <= '0;
      wcnt            <= '0;
      str_sent        <= 1'b0;
      cap_match       <= 1'b0;
      cap_tmo         <= 1'b0;
      cap_index       <= '0;
      tx_q            <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.res_match   <= 1'b0;
      bus.res_index   <= '0;
      bus.ovf         <= 1'b0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      wcnt            <= wcnt_n;
      str_sent        <= str_sent_n;
      cap_match       <= cap_match_n;
      cap_tmo         <= cap_tmo_n;
      cap_index       <= cap_index_n;
      tx_q            <= tx_d;
      bus.busy        <= busy_d;
      bus.done        <= done_d;
      bus.timeout_err <= tmo_d;
      bus.res_match   <= match_d;
      bus.res_index   <= index_d;
      bus.ovf         <= ovf_d;
    end
  end

  // Next-state and job bookkeeping.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    wcnt_n      = wcnt;
    str_sent_n  = str_sent;
    cap_match_n = cap_match;
    cap_tmo_n   = cap_tmo;
    cap_index_n = cap_index;
    case (state)
      IDLE: begin
        if (start_ok_c) begin
          idx_n   = '0;
          state_n = (bus.keep_string && str_sent) ? SEND_PAT : SEND_STR;
        end
      end
      SEND_STR: begin
        if ((idx + SLW'(1)) == str_len) begin
          idx_n      = '0;
          str_sent_n = 1'b1;
          state_n    = SEND_PAT;
        end else begin
          idx_n = idx + SLW'(1);
        end
      end
      SEND_PAT: begin
        if ((idx + SLW'(1)) == SLW'(pat_len)) begin
          idx_n   = '0;
          state_n = GAP;
        end else begin
          idx_n = idx + SLW'(1);
        end
      end
      GAP: begin
        wcnt_n  = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // A result arriving on the final counted cycle still counts as valid.
        if (bus.sme_valid) begin
          cap_match_n = bus.sme_match;
          cap_index_n = bus.sme_match_index;
          cap_tmo_n   = 1'b0;
          state_n     = REPORT;
        end else if (wcnt == CW'(TIMEOUT - 1)) begin
          cap_match_n = 1'b0;
          cap_index_n = '0;
          cap_tmo_n   = 1'b1;
          str_sent_n  = 1'b0;
          state_n     = REPORT;
        end else begin
          wcnt_n = wcnt + CW'(1);
        end
      end
      REPORT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output values; everything lags the state by one register stage so data and strobes align.
  always_comb begin
    tx_d    = '0;
    busy_d  = (state != IDLE);
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    match_d = bus.res_match;
    index_d = bus.res_index;
    ovf_d   = str_ovf || pat_ovf;
    case (state)
      SEND_STR: begin
        tx_d.isstring = 1'b1;
        tx_d.chardata = str_rd_c;
      end
      SEND_PAT: begin
        tx_d.ispattern = 1'b1;
        tx_d.chardata  = pat_rd_c;
      end
      REPORT: begin
        done_d  = 1'b1;
        tmo_d   = cap_tmo;
        match_d = cap_match;
        index_d = cap_index;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/sme_feeder.md
Name: sme_feeder

Overview:
Host-side driver for the string-matching engine. The host loads one string and one pattern into local buffers, then pulses start. The block serialises both buffers onto the engine's chardata/isstring/ispattern interface, waits for the engine's valid pulse, and returns match/index to the host. It sits between the testbench or host controller and the matching engine, as the transmitting end of that protocol.

Parameters:
STR_DEPTH, 32, string buffer capacity in characters (index width 5).
PAT_DEPTH, 10, pattern buffer capacity, including '^' and '$' markers (8 literal chars plus 2 markers).
TIMEOUT, 1024, maximum cycles spent in WAIT before aborting.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the next rising clk edge)
wr_en  in  1  buffer write strobe; accepted only in IDLE
wr_sel  in  1  0 = string buffer, 1 = pattern buffer
wr_data  in  8  ASCII character appended to the selected buffer
clear  in  1  IDLE only: zero both lengths and the overflow flag
start  in  1  begin a job; sampled only in IDLE
keep_string  in  1  with start: skip the string phase and reuse the engine's stored string
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a result is available
res_match  out  1  captured match bit; held until the next done
res_index  out  5  captured match index; held until the next done
timeout_err  out  1  one-cycle pulse, concurrent with done, on timeout
ovf  out  1  sticky: a write was dropped because its buffer was full
chardata  out  8  character to the engine
isstring  out  1  chardata is a string character
ispattern  out  1  chardata is a pattern character
sme_valid  in  1  engine result strobe
sme_match  in  1  engine match result
sme_match_index  in  5  engine match index

Behaviour:
- Reset values: all outputs 0; str_len = pat_len = 0; str_sent = 0; state IDLE. Buffer contents are not cleared. Reset mid-job aborts immediately with no done pulse.
- Writes: wr_en in IDLE stores wr_data at buf[len] and increments len.
  - If len == depth, the write is dropped and ovf is set.
  - wr_en outside IDLE is ignored and does not set ovf.
  - clear has priority over wr_en in the same cycle.
- start legality:
  - start is legal when pat_len != 0 AND (str_len != 0 OR (keep_string AND str_sent)).
  - An illegal start is ignored: no state change, no pulse.
- States: IDLE -> SEND_STR -> SEND_PAT -> GAP -> WAIT -> REPORT -> IDLE.
  - Legal start with keep_string and str_sent: go IDLE -> SEND_PAT directly.
- Timing, with start sampled at edge T, string length Ls and pattern length Lp:
  - isstring = 1 with chardata = str[0..Ls-1] during cycles T+1 .. T+Ls.
  - ispattern = 1 with chardata = pat[0..Lp-1] during the next Lp cycles. Markers are sent verbatim.
  - GAP: exactly one cycle with isstring = ispattern = 0 and chardata = 0. The engine needs this cycle to leave its load state.
  - isstring and ispattern are never high together; both are low outside SEND_STR and SEND_PAT.
  - str_sent is set on completion of SEND_STR.
- WAIT: counts cycles from 0.
  - sme_valid == 1: capture sme_match and sme_match_index, then go to REPORT.
  - Counter reaches TIMEOUT-1 without sme_valid: res_match = 0, res_index = 0, timeout_err pulses in REPORT, and str_sent is cleared.
  - sme_valid arriving in the same cycle as the timeout limit counts as valid (valid wins).
- REPORT: done = 1 for one cycle, then IDLE. Total latency from start to done = Ls + Lp + 1 + wait_cycles + 1.
- Buffer lengths persist across jobs, so a new pattern may be loaded after clear-less re-use. To replace only the pattern, the host uses clear and then rewrites both buffers, or uses keep_string.
- sme_valid sampled outside WAIT is ignored.
- All outputs are registered. chardata comes from a registered read of the buffer, pipelined so that data and strobes align.

Decomposition:
- Package sme_pkg holds:
  - character constants HAT = 8'h5E, DOLLAR = 8'h24, DOT = 8'h2E, SPACE = 8'h20;
  - the state encoding for IDLE, SEND_STR, SEND_PAT, GAP, WAIT, REPORT;
  - the index widths derived from STR_DEPTH and PAT_DEPTH.
- One sub-module, sme_char_buf: parameterised depth, append write port, length counter, overflow flag, indexed read. It is instantiated twice, once for the string and once for the pattern.

Test Plan:
- Load "hello world" (11 chars) and pattern "wor", start -> 11 isstring cycles, then 3 ispattern cycles, then 1 gap cycle. Engine model returns valid with match=1, index=6 -> res_match=1, res_index=6, single-cycle done, busy low on the following cycle.
- Pattern "^w.r$" with keep_string=1 after the previous job -> zero isstring cycles; 5 ispattern cycles carrying 5E,77,2E,72,24; done with the model's result (match=0).
- Write 33 string chars -> 32 stored, ovf=1. Write during busy -> ignored, ovf unchanged. clear -> ovf=0, lengths 0.
- Start with pat_len=0, or keep_string=1 right after reset -> no strobes, busy stays 0.
- Model never asserts valid, TIMEOUT=16 -> done and timeout_err together 16 cycles after entering WAIT, res_match=0. A following keep_string start is illegal.
- Drive reset=0 during SEND_PAT -> next cycle all outputs 0, state IDLE, no done; a new load and start completes normally.
